// File: rtl/alu_pkg.sv
// Shared ALU opcode and sequencer state types.
// Used by the ALU decoder and the multi-cycle mul/div sequencer.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_LUI = 4'b1000,
        ALU_MUL = 4'b1001,
        ALU_DIV = 4'b1010,
        ALU_MOD = 4'b1011,
        ALU_NOR = 4'b1100
    } alu_ops_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_MOD);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// acc holds the partial product / remainder, mq the multiplier / quotient.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] md,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] mq_n,
    output logic [WIDTH-1:0] md_n
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Bit WIDTH of diff is the borrow: set when trial < divisor.
    assign trial = {acc, mq[WIDTH-1]};
    assign diff  = trial - {1'b0, md};

    always_comb begin
        acc_n = acc;
        mq_n  = mq;
        md_n  = md;
        if (is_div) begin
            mq_n  = {mq[WIDTH-2:0], ~diff[WIDTH]};
            acc_n = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        end else begin
            acc_n = mq[0] ? acc + md : acc;
            mq_n  = mq >> 1;
            md_n  = md << 1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV/MOD sequencer, one result bit per cycle.
// Define MULDIV_SIGNED_EN for two's-complement operands.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    import alu_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        state;
    alu_ops_t         op;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] md;
    logic             neg_a;
    logic             neg_b;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] mq_n;
    logic [WIDTH-1:0] md_n;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] fixed;
    logic             flip;
    logic             div_req;

`ifdef MULDIV_SIGNED_EN
    assign sa = a[WIDTH-1];
    assign sb = b[WIDTH-1];
`else
    assign sa = 1'b0;
    assign sb = 1'b0;
`endif

    assign mag_a   = sa ? (~a + 1'b1) : a;
    assign mag_b   = sb ? (~b + 1'b1) : b;
    assign div_req = (alu_control == ALU_DIV) || (alu_control == ALU_MOD);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div (op != ALU_MUL),
        .acc    (acc),
        .mq     (mq),
        .md     (md),
        .acc_n  (acc_n),
        .mq_n   (mq_n),
        .md_n   (md_n)
    );

    // Remainder follows the dividend sign; product and quotient the xor.
    always_comb begin
        raw   = (op == ALU_DIV) ? mq_n : acc_n;
        flip  = (op == ALU_MOD) ? neg_a : (neg_a ^ neg_b);
        fixed = flip ? (~raw + 1'b1) : raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op          <= ALU_AND;
            cnt         <= '0;
            acc         <= '0;
            mq          <= '0;
            md          <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && is_muldiv(alu_control)) begin
                        op    <= alu_ops_t'(alu_control);
                        neg_a <= sa;
                        neg_b <= sb;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        if (div_req && (b == '0)) begin
                            state       <= S_FINISH;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            result      <= (alu_control == ALU_DIV) ? '1 : a;
                        end else begin
                            state <= S_RUN;
                            if (alu_control == ALU_MUL) begin
                                mq <= mag_b;
                                md <= mag_a;
                            end else begin
                                mq <= mag_a;
                                md <= mag_b;
                            end
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_n;
                    mq  <= mq_n;
                    md  <= md_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state       <= S_FINISH;
                        done        <= 1'b1;
                        result      <= fixed;
                        div_by_zero <= 1'b0;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
